// File: rtl/zbt_bank_arb_pkg.sv
// rtl/zbt_bank_arb_pkg.sv - shared parameters and types for the ZBT bank arbiter
// Purpose: bank geometry, pipeline latency, FIFO depth and the write FIFO entry type.
// Ports: none (package).
package zbt_bank_arb_pkg;

  localparam int AW      = 19;               // ZBT address width
  localparam int DW      = 36;               // two 18-bit pixels
  localparam int DEPTH   = 8;                // write FIFO entries, power of two
  localparam int ZBT_LAT = 2;                // address-to-data latency on the bank pins
  localparam int CW      = $clog2(DEPTH) + 1; // occupancy counter width

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } fifo_entry_t;

  // Per-cycle bank ownership decision.
  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } grant_e;

endpackage

// File: rtl/zbt_bank_arb_if.sv
// rtl/zbt_bank_arb_if.sv - bus bundle between the arbiter, its clients and the ZBT bank
// Purpose: groups the write stream, display read stream, bank pins and status.
// Ports (slave = arbiter view):
//   in : wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_read_data
//   out: rd_data_valid, rd_data, mem_addr, mem_we, mem_write_data, fifo_count, fifo_overflow
interface zbt_bank_arb_if;
  import zbt_bank_arb_pkg::*;

  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_data_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_overflow;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_read_data,
    output rd_data_valid, rd_data, mem_addr, mem_we, mem_write_data, fifo_count, fifo_overflow
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_read_data,
    input  rd_data_valid, rd_data, mem_addr, mem_we, mem_write_data, fifo_count, fifo_overflow
  );

endinterface

// File: rtl/zbt_bank_arb_wr_fifo.sv
// rtl/zbt_bank_arb_wr_fifo.sv - synchronous write FIFO for processed pixel words
// Purpose: buffers {addr, data} entries until the bank has an idle cycle.
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_push, i_entry    push request and entry
//   i_pop              pop request (ignored when empty)
//   o_head             entry at the head, valid when !o_empty
//   o_full, o_empty    occupancy flags
//   o_count            current occupancy
module zbt_wr_fifo
  import zbt_bank_arb_pkg::*;
#(
  parameter int DEPTH_P = 8
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_push,
  input  fifo_entry_t                  i_entry,
  input  logic                         i_pop,
  output fifo_entry_t                  o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH_P):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH_P);

  fifo_entry_t      r_mem [DEPTH_P];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH_P));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_do_push) begin
      r_mem[r_wptr] <= i_entry;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (PTR_W+1)'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/zbt_bank_arb.sv
// rtl/zbt_bank_arb.sv - single-port ZBT bank arbiter and pipeline sequencer
// Purpose: display reads win every cycle; buffered processed writes drain into
// idle bank cycles; write data and read returns are aligned to the ZBT pipeline.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   io_bus           slave side of zbt_bank_arb_if (streams, bank pins, status)
module zbt_bank_arb
  import zbt_bank_arb_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  zbt_bank_arb_if.slave         io_bus
);

  grant_e        w_grant;
  fifo_entry_t   w_in;
  fifo_entry_t   w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic [CW-1:0] w_count;

  logic [AW-1:0] r_mem_addr;
  logic          r_mem_we;
  // Stage 0 lines up with the address cycle; the last stage is the bank data beat.
  logic [DW-1:0] r_wd [ZBT_LAT+1];
  // Read tag: bit k set means a read address was on the pins k cycles ago.
  logic [ZBT_LAT:0] r_rv;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;
  logic          r_overflow;

  always_comb begin
    w_grant = GNT_IDLE;
    if (io_bus.rd_req)  w_grant = GNT_READ;
    else if (!w_empty)  w_grant = GNT_WRITE;
  end

  assign w_pop     = (w_grant == GNT_WRITE);
  assign w_in.addr = io_bus.wr_addr;
  assign w_in.data = io_bus.wr_data;

  zbt_wr_fifo #(.DEPTH_P(DEPTH)) u_wr_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (io_bus.wr_valid),
    .i_entry (w_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem_addr <= '0;
      r_mem_we   <= 1'b0;
      for (int i = 0; i <= ZBT_LAT; i++) r_wd[i] <= '0;
      r_rv       <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_mem_we <= (w_grant == GNT_WRITE);
      // Address holds through idle cycles.
      if (w_grant == GNT_READ)       r_mem_addr <= io_bus.rd_addr;
      else if (w_grant == GNT_WRITE) r_mem_addr <= w_head.addr;

      if (w_pop) r_wd[0] <= w_head.data;
      for (int i = 1; i <= ZBT_LAT; i++) r_wd[i] <= r_wd[i-1];

      r_rv       <= {r_rv[ZBT_LAT-1:0], (w_grant == GNT_READ)};
      r_rd_valid <= r_rv[ZBT_LAT];
      if (r_rv[ZBT_LAT]) r_rd_data <= io_bus.mem_read_data;

      if (io_bus.wr_valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign io_bus.mem_addr       = r_mem_addr;
  assign io_bus.mem_we         = r_mem_we;
  assign io_bus.mem_write_data = r_wd[ZBT_LAT];
  assign io_bus.rd_data_valid  = r_rd_valid;
  assign io_bus.rd_data        = r_rd_data;
  assign io_bus.fifo_count     = w_count;
  assign io_bus.fifo_overflow  = r_overflow;

endmodule

// File: tb/tb_zbt_bank_arb.sv
// tb/tb_zbt_bank_arb.sv - self-checking bench for zbt_bank_arb
module tb_zbt_bank_arb;
  import zbt_bank_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  zbt_bank_arb_if bus();

  zbt_bank_arb dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = -1;

  // Reference model: a queue of pending writes plus per-cycle expected events.
  fifo_entry_t   mq[$];
  logic          m_ov;
  logic          m_we_at  [int];
  logic [AW-1:0] m_addr_at[int];
  logic [DW-1:0] m_wd_at  [int];
  logic [DW-1:0] m_rd_at  [int];
  bit            m_rst_at [int];
  logic [AW-1:0] hist     [int];
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_rd;
  int            e_count;
  logic          e_ov;

  function automatic logic [DW-1:0] bank_fn(logic [AW-1:0] a);
    if (a == 19'h7FFFF) return 36'h123456789;
    return {a[16:0], a} ^ 36'h5A5A5A5A5;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {4'($urandom_range(0, 15)), 32'($urandom)};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expected);
    n_vec++;
    assert (obs === expected) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, expected);
    end
  endtask

  task automatic step(bit rst, bit wv, logic [AW-1:0] wa, logic [DW-1:0] wd,
                      bit rr, logic [AW-1:0] ra);
    fifo_entry_t e;
    bit          pop;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc > 0) begin
      if (m_rst_at.exists(cyc)) begin
        e_addr = '0;
        e_rd   = '0;
      end
      if (m_addr_at.exists(cyc)) e_addr = m_addr_at[cyc];
      if (m_rd_at.exists(cyc))   e_rd   = m_rd_at[cyc];
      chk("mem_we", 64'(bus.mem_we), 64'(m_we_at.exists(cyc) ? m_we_at[cyc] : 1'b0));
      chk("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
      chk("rd_data_valid", 64'(bus.rd_data_valid), 64'(m_rd_at.exists(cyc)));
      chk("rd_data", 64'(bus.rd_data), 64'(e_rd));
      if (m_wd_at.exists(cyc))
        chk("mem_write_data", 64'(bus.mem_write_data), 64'(m_wd_at[cyc]));
      else if (m_rst_at.exists(cyc))
        chk("mem_write_data_rst", 64'(bus.mem_write_data), 64'd0);
      chk("fifo_count", 64'(bus.fifo_count), 64'(e_count));
      chk("fifo_overflow", 64'(bus.fifo_overflow), 64'(e_ov));
    end

    // Bank model: data for the address seen on the pins ZBT_LAT cycles ago.
    hist[cyc] = bus.mem_addr;
    bus.mem_read_data = hist.exists(cyc - ZBT_LAT) ? bank_fn(hist[cyc - ZBT_LAT]) : '0;

    reset        = rst;
    bus.wr_valid = wv;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd_req   = rr;
    bus.rd_addr  = ra;

    if (rst) begin
      mq.delete();
      m_we_at.delete();
      m_addr_at.delete();
      m_wd_at.delete();
      m_rd_at.delete();
      m_rst_at.delete();
      m_rst_at[cyc+1] = 1'b1;
      m_ov = 1'b0;
    end else begin
      pop = !rr && (mq.size() > 0);
      if (rr) begin
        m_we_at[cyc+1]            = 1'b0;
        m_addr_at[cyc+1]          = ra;
        m_rd_at[cyc+2+ZBT_LAT]    = bank_fn(ra);
      end else if (pop) begin
        e = mq.pop_front();
        m_we_at[cyc+1]            = 1'b1;
        m_addr_at[cyc+1]          = e.addr;
        m_wd_at[cyc+1+ZBT_LAT]    = e.data;
      end
      if (wv) begin
        if (mq.size() < DEPTH) mq.push_back('{addr: wa, data: wd});
        else m_ov = 1'b1;
      end
    end
    e_count = mq.size();
    e_ov    = m_ov;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0);
  endtask

  initial begin
    reset             = 1'b1;
    bus.wr_valid      = 1'b0;
    bus.wr_addr       = '0;
    bus.wr_data       = '0;
    bus.rd_req        = 1'b0;
    bus.rd_addr       = '0;
    bus.mem_read_data = '0;
    m_ov              = 1'b0;
    e_addr            = '0;
    e_rd              = '0;
    e_count           = 0;
    e_ov              = 1'b0;

    // Cycles 0-1 reset, single write at 5, single read at 10, collision at 20.
    step(1, 0, '0, '0, 0, '0);
    step(1, 0, '0, '0, 0, '0);
    idle(3);
    step(0, 1, 19'h00010, 36'hABCDE1234, 0, '0);
    idle(4);
    step(0, 0, '0, '0, 1, 19'h7FFFF);
    idle(9);
    step(0, 1, 19'h00222, rnd_data(), 1, 19'h00333);
    idle(8);

    // Overflow: reads hog the bank while the write stream keeps coming.
    for (int i = 0; i < 12; i++) step(0, 1, 19'(i), rnd_data(), 1, 19'($urandom));
    for (int i = 12; i < 16; i++) step(0, 1, 19'(i), rnd_data(), 0, '0);
    idle(16);

    // Full FIFO with simultaneous pop: push accepted, no overflow.
    step(1, 0, '0, '0, 0, '0);
    for (int i = 0; i < 8; i++) step(0, 1, 19'(16'h100 + i), rnd_data(), 1, 19'($urandom));
    step(0, 1, 19'h001FF, rnd_data(), 0, '0);
    idle(14);

    // Reset one cycle after a read grant with three writes queued.
    for (int i = 0; i < 3; i++) step(0, 1, 19'(16'h200 + i), rnd_data(), 1, 19'(16'h300 + i));
    step(1, 1, 19'h00777, rnd_data(), 1, 19'h00777);
    idle(8);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) < 6, 19'($urandom), rnd_data(),
           $urandom_range(0, 9) < 5, 19'($urandom));
    end
    idle(14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
